// File: rtl/range_sweep_gen_pkg.sv
// range_sweep_pkg: shared types and defaults for the sweep generator; RANGE_SWEEP_REPEAT_EN adds the repeat flag to the config
package range_sweep_pkg;
    localparam int W_DEF = 32;
    localparam int DLY_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, EMIT, GAP} sweep_state_e;
    typedef struct packed {
        logic [W_DEF-1:0] start;
        logic [W_DEF-1:0] stop;
        logic [W_DEF-1:0] step;
        logic [DLY_W_DEF-1:0] delay;
`ifdef RANGE_SWEEP_REPEAT_EN
        logic rpt;
`endif
    } sweep_cfg_t;
endpackage

// File: rtl/range_sweep_gen_if.sv
// range_sweep_gen_if: control, config and valid/ready stream of the sweep generator; RANGE_SWEEP_REPEAT_EN adds cfg_repeat_i
interface range_sweep_gen_if
    import range_sweep_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int DLY_W = DLY_W_DEF
);
    logic start_i;
    logic [W-1:0] cfg_start_i;
    logic [W-1:0] cfg_stop_i;
    logic [W-1:0] cfg_step_i;
    logic [DLY_W-1:0] cfg_delay_i;
`ifdef RANGE_SWEEP_REPEAT_EN
    logic cfg_repeat_i;
`endif
    logic abort_i;
    logic [W-1:0] val_o;
    logic valid_o;
    logic ready_i;
    logic busy_o;
    logic done_o;
    modport master (
`ifdef RANGE_SWEEP_REPEAT_EN
        input cfg_repeat_i,
`endif
        input start_i, cfg_start_i, cfg_stop_i, cfg_step_i, cfg_delay_i, abort_i, ready_i,
        output val_o, valid_o, busy_o, done_o
    );
    modport slave (
`ifdef RANGE_SWEEP_REPEAT_EN
        output cfg_repeat_i,
`endif
        output start_i, cfg_start_i, cfg_stop_i, cfg_step_i, cfg_delay_i, abort_i, ready_i,
        input val_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/range_sweep_gen_delay_cnt.sv
// sweep_delay_cnt: loadable down-counter timing the idle gap between beats
module sweep_delay_cnt #(
    parameter int DLY_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DLY_W-1:0] value,
    output logic             zero
);
    logic [DLY_W-1:0] cnt;
    // load on request, otherwise count down and rest at zero
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - DLY_W'(1);
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/range_sweep_gen.sv
// range_sweep_gen: emits start, start+step, .. stop over valid/ready with optional gap; RANGE_SWEEP_REPEAT_EN enables continuous passes
module range_sweep_gen
    import range_sweep_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int DLY_W = DLY_W_DEF
) (
    input logic clk,
    input logic rst_n,
    range_sweep_gen_if.master bus
);
    sweep_state_e state;
    sweep_cfg_t cfg;
    logic [W-1:0] cur_start, cur_stop, cur_step;
    logic [DLY_W-1:0] dly_cfg;
    logic [W:0] nxt;
    logic last, hs, rpt, dly_zero;
    assign cur_start = cfg.start[W-1:0];
    assign cur_stop  = cfg.stop[W-1:0];
    assign cur_step  = cfg.step[W-1:0];
    assign dly_cfg   = cfg.delay[DLY_W-1:0];
    // one extra bit so a step past the top of the range ends the sweep instead of wrapping
    assign nxt  = {1'b0, bus.val_o} + {1'b0, cur_step};
    assign last = nxt > {1'b0, cur_stop};
    assign hs   = (state == EMIT) && bus.ready_i;
`ifdef RANGE_SWEEP_REPEAT_EN
    assign rpt = cfg.rpt;
`else
    assign rpt = 1'b0;
`endif
    sweep_delay_cnt #(.DLY_W(DLY_W)) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .load (hs),
        .value(dly_cfg - DLY_W'(1)),
        .zero (dly_zero)
    );
    // sweep FSM with registered stream and status outputs; abort beats everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cfg         <= '0;
            bus.val_o   <= '0;
            bus.valid_o <= 1'b0;
            bus.busy_o  <= 1'b0;
            bus.done_o  <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            if (bus.abort_i) begin
                state       <= IDLE;
                bus.val_o   <= '0;
                bus.valid_o <= 1'b0;
                bus.busy_o  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start_i) begin
                        cfg.start <= W_DEF'(bus.cfg_start_i);
                        cfg.stop  <= W_DEF'(bus.cfg_stop_i);
                        cfg.step  <= (bus.cfg_step_i == '0) ? W_DEF'(1) : W_DEF'(bus.cfg_step_i);
                        cfg.delay <= DLY_W_DEF'(bus.cfg_delay_i);
`ifdef RANGE_SWEEP_REPEAT_EN
                        cfg.rpt   <= bus.cfg_repeat_i;
`endif
                        if (bus.cfg_start_i <= bus.cfg_stop_i) begin
                            state       <= EMIT;
                            bus.val_o   <= bus.cfg_start_i;
                            bus.valid_o <= 1'b1;
                            bus.busy_o  <= 1'b1;
                        end else bus.done_o <= 1'b1;
                    end
                    EMIT: if (bus.ready_i) begin
                        bus.done_o <= last;
                        if (last && !rpt) begin
                            state       <= IDLE;
                            bus.valid_o <= 1'b0;
                            bus.busy_o  <= 1'b0;
                        end else begin
                            bus.val_o   <= last ? cur_start : nxt[W-1:0];
                            state       <= (dly_cfg == '0) ? EMIT : GAP;
                            bus.valid_o <= (dly_cfg == '0);
                        end
                    end
                    GAP: if (dly_zero) begin
                        state       <= EMIT;
                        bus.valid_o <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_range_sweep_gen.sv
// tb_range_sweep_gen: randomized scoreboard bench for range_sweep_gen at W=8
module tb_range_sweep_gen;
    localparam int W = 8;
    localparam int DLY_W = 16;
    typedef struct {int v; bit last;} beat_t;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    range_sweep_gen_if #(.W(W), .DLY_W(DLY_W)) bus ();
    range_sweep_gen #(.W(W), .DLY_W(DLY_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    beat_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cur_delay = 0;
    int empty_pend = 0;
    bit done_next = 0;
    bit rnd_ready = 0;

    task automatic check(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // consumer ready: always high or a fair coin, changed just after each edge
    initial begin
        bus.ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ready_i = rnd_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    // monitor: pops expected beats on handshakes, checks stability, gaps and done pulses
    initial begin
        bit prev_pend = 0;
        int prev_val = 0;
        bit gap_arm = 0;
        int gap_cnt = 0;
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.busy_o) gap_arm = 0;
            if (done_next) begin
                check("done_after_last", bus.done_o, 1);
                done_next = 0;
            end else if (bus.done_o) begin
                check("done_expected", empty_pend > 0, 1);
                if (empty_pend > 0) empty_pend--;
            end
            if (prev_pend && bus.valid_o) check("val_stable", bus.val_o, prev_val);
            if (gap_arm) begin
                if (!bus.valid_o) gap_cnt++;
                else begin
                    check("gap_len", gap_cnt, cur_delay);
                    gap_arm = 0;
                end
            end
            if (rst_n && !bus.abort_i && bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) check("extra_beat", bus.val_o, -1);
                else begin
                    b = exp_q.pop_front();
                    check("beat", bus.val_o, b.v);
                    if (b.last) done_next = 1;
                    else begin
                        gap_arm = 1;
                        gap_cnt = 0;
                    end
                end
            end
            prev_pend = rst_n && !bus.abort_i && bus.valid_o && !bus.ready_i;
            prev_val = int'(bus.val_o);
        end
    end

    task automatic drive_cfg(int s, int e, int st, int d, bit rpt);
        bus.cfg_start_i = W'(s);
        bus.cfg_stop_i  = W'(e);
        bus.cfg_step_i  = W'(st);
        bus.cfg_delay_i = DLY_W'(d);
`ifdef RANGE_SWEEP_REPEAT_EN
        bus.cfg_repeat_i = rpt;
`else
        if (rpt) $display("repeat requested without repeat build");
`endif
        cur_delay = d;
    endtask

    // reference model: the arithmetic sequence start..stop, no wrap, repeated for each pass
    task automatic model(int s, int e, int st, int passes);
        int stp = (st == 0) ? 1 : st;
        beat_t b;
        if (s > e) empty_pend++;
        else for (int p = 0; p < passes; p++) begin
            int v = s;
            forever begin
                b.v = v;
                b.last = (v + stp > e);
                exp_q.push_back(b);
                if (b.last) break;
                v += stp;
            end
        end
    endtask

    task automatic run(int s, int e, int st, int d, bit rpt, int passes);
        drive_cfg(s, e, st, d, rpt);
        model(s, e, st, passes);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        if (s <= e) begin
            check("start_valid", bus.valid_o, 1);
            check("start_val", bus.val_o, s);
            check("start_busy", bus.busy_o, 1);
        end else begin
            check("empty_done", bus.done_o, 1);
            check("empty_valid", bus.valid_o, 0);
        end
        for (int c = 0; c < 3000 && (exp_q.size() != 0 || (!rpt && (done_next || empty_pend != 0))); c++) begin
            @(posedge clk);
            #1;
        end
        check("drain", exp_q.size() + int'(!rpt && done_next) + (rpt ? 0 : empty_pend), 0);
        if (rpt) begin
            bus.abort_i = 1'b1;
            @(posedge clk);
            #1;
            bus.abort_i = 1'b0;
            @(negedge clk);
            check("rpt_abort_busy", bus.busy_o, 0);
            check("rpt_abort_valid", bus.valid_o, 0);
        end else check("end_busy", bus.busy_o, 0);
        exp_q.delete();
        done_next = 0;
        empty_pend = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic abort_mid(bit use_rst);
        drive_cfg(0, 200, 1, 1, 0);
        model(0, 200, 1, 1);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        if (use_rst) rst_n = 1'b0;
        else bus.abort_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.abort_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check(use_rst ? "rst_valid" : "abort_valid", bus.valid_o, 0);
        check(use_rst ? "rst_busy" : "abort_busy", bus.busy_o, 0);
        check(use_rst ? "rst_val" : "abort_val", bus.val_o, 0);
        check(use_rst ? "rst_done" : "abort_done", bus.done_o, 0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        drive_cfg(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_val", bus.val_o, 0);
        check("reset_valid", bus.valid_o, 0);
        check("reset_busy", bus.busy_o, 0);
        check("reset_done", bus.done_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(3, 9, 2, 0, 0, 1);
        run(0, 4, 1, 2, 0, 1);
        rnd_ready = 1;
        run(10, 20, 3, 0, 0, 1);
        run(10, 20, 3, 1, 0, 1);
        rnd_ready = 0;
        run(250, 255, 4, 0, 0, 1);
        run(5, 4, 1, 0, 0, 1);
        run(7, 9, 0, 0, 0, 1);
        run(255, 255, 1, 3, 0, 1);
        abort_mid(0);
        run(1, 3, 1, 0, 0, 1);
        abort_mid(1);
        run(2, 6, 2, 1, 0, 1);
        for (int i = 0; i < 12; i++) begin
            int s = int'($urandom_range(0, 240));
            int e = ($urandom % 6 == 0 && s > 0) ? s - 1 : s + int'($urandom_range(0, 255 - s));
            rnd_ready = 1'($urandom % 2);
            run(s, e, int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 0, 1);
        end
        rnd_ready = 0;
`ifdef RANGE_SWEEP_REPEAT_EN
        run(1, 2, 1, 0, 1, 3);
        rnd_ready = 1;
        run(3, 12, 4, 1, 1, 2);
        rnd_ready = 0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
